ibex_register_file_mp: RTL and testbench
========================================

Name: ibex_register_file_mp

Overview:
Parametrised multi-port register file, successor to the single-write, dual-read flop register file used by the Ibex core.
- Generalised in register count, data width (including ECC-widened words), number of read ports and number of write ports.
- Adds optional same-cycle write-through, a sequential secure-wipe engine with a handshake, and a registered, sticky write-enable glitch alarm.
- Sits between the decode/writeback stages and the ALU/LSU operand muxes; the top level instantiates it in place of the FF variant.

Parameters:
- NumRegs, 32, architectural registers (16 for RV32E, 32 otherwise); register 0 is hardwired.
- DataWidth, 32, word width (39 when ECC is enabled).
- NumReadPorts, 2, combinational read ports, legal range 1..4.
- NumWritePorts, 1, write ports, legal range 1..2.
- WriteThrough, 0, 1 = a read of an address written in the same cycle returns the incoming write data.
- WrenCheck, 1, 1 = enable the write-enable one-hot glitch check.
- WordZeroVal, '0, value returned for x0, for out-of-range addresses and after reset or wipe.

Ports:
- clk  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- raddr_i  in  5*NumReadPorts  read addresses; port p occupies bits [5p+4:5p].
- rdata_o  out  DataWidth*NumReadPorts  read data, combinational from raddr_i.
- waddr_i  in  5*NumWritePorts  write addresses.
- wdata_i  in  DataWidth*NumWritePorts  write data.
- we_i  in  NumWritePorts  write enables.
- wipe_req_i  in  1  request a wipe of all registers.
- wipe_busy_o  out  1  wipe in progress.
- wipe_done_o  out  1  single-cycle pulse when a wipe completes.
- err_o  out  1  sticky write-enable glitch alarm.

Behaviour:
- Reset (asynchronous, rst_i high):
  - All registers 1..NumRegs-1 are set to WordZeroVal.
  - The FSM goes to IDLE and the wipe counter to 1.
  - wipe_busy_o=0, wipe_done_o=0, err_o=0.
  - rdata_o follows the register contents, so it reads WordZeroVal.
- Reads:
  - Pure combinational, zero latency.
  - Address 0, or any address >= NumRegs, returns WordZeroVal.
  - With WriteThrough=1, if a write that takes effect this cycle targets the same address, that write's wdata is returned; the highest-index write port wins.
  - With WriteThrough=0, the old contents are returned and the new value is visible from the next cycle.
- Writes:
  - Applied at the rising edge of clk when we_i[k]=1, waddr != 0, waddr < NumRegs and the FSM is IDLE.
  - Writes to address 0 or to out-of-range addresses are silently dropped.
  - If two ports target the same address in the same cycle, the higher-index port wins; this is not an error.
- Wipe FSM, states IDLE, WIPE, DONE:
  - IDLE -> WIPE: when wipe_req_i=1.
  - WIPE: each cycle writes WordZeroVal to the register selected by the counter, then increments the counter. When counter = NumRegs-1 has been written, go to DONE.
  - DONE: asserts wipe_done_o for exactly one cycle, resets the counter to 1, then returns to IDLE.
  - wipe_busy_o=1 in WIPE and DONE; all architectural writes are ignored while it is high.
  - Timing: a request accepted in cycle t gives busy from t+1 to t+NumRegs (31 WIPE cycles plus 1 DONE cycle for NumRegs=32) and done at t+NumRegs.
  - wipe_req_i while busy is ignored, with no queuing.
  - wipe_req_i held high re-triggers from IDLE, so a back-to-back wipe starts the cycle after DONE.
  - Reads during a wipe return current contents: registers already cleared read WordZeroVal, the rest keep their old values.
  - Reset mid-wipe: immediate return to IDLE, with all registers at WordZeroVal.
- Glitch check (WrenCheck=1):
  - Each write port's decoded enable vector over registers 1..NumRegs-1 must be one-hot or zero.
  - The wipe engine's decoded enable must not overlap any port enable.
  - Any violation sets an internal flag; err_o is that flag registered, so it rises one cycle later and stays high until rst_i.
  - With WrenCheck=0, err_o is tied to 0.

Test Plan:
- Reset, then write x5=0xDEADBEEF on port 0 and read it on both ports the next cycle -> 0xDEADBEEF on both; reading x0 -> WordZeroVal; writing x0=0x1234 -> x0 still reads WordZeroVal.
- NumRegs=16: write x20=0xAA -> dropped; reading x20 -> WordZeroVal; x4 is unaffected.
- NumWritePorts=2, both ports write x7 (0x11 on port 0, 0x22 on port 1) -> x7=0x22. With WriteThrough=1, a same-cycle read of x7 -> 0x22; with WriteThrough=0 it returns the old value.
- Fill x1..x31 with distinct values, then pulse wipe_req_i at cycle t:
  - busy over t+1..t+32 and wipe_done_o high only at t+32;
  - a write to x3 during busy is ignored;
  - all registers read WordZeroVal afterwards.
- Assert rst_i during the 10th wipe cycle -> busy=0 and done=0 immediately, all registers at WordZeroVal, and the FSM accepts a new wipe_req_i.
- Force a two-hot decoded enable on port 0 for one cycle -> err_o rises the next cycle and stays high until rst_i; the same scenario with WrenCheck=0 -> err_o stays 0.

Source files
------------

// File: rtl/ibex_register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : ibex_register_file_mp_if
// Description : Bundle of the register file's read/write/wipe/alarm signals.
//               master = the core side (drives addresses, data, enables and
//               wipe request), slave = the register file.
//   raddr_i     [5*NumReadPorts]         read addresses, port p at [5p+4:5p]
//   rdata_o     [DataWidth*NumReadPorts] combinational read data
//   waddr_i     [5*NumWritePorts]        write addresses
//   wdata_i     [DataWidth*NumWritePorts] write data
//   we_i        [NumWritePorts]          write enables
//   wipe_req_i  wipe request
//   wipe_busy_o wipe in progress
//   wipe_done_o one-cycle pulse at wipe completion
//   err_o       sticky write-enable glitch alarm
// Revision    : 1.0 - initial release
// ============================================================================
interface ibex_register_file_mp_if #(
  parameter int unsigned NumReadPorts  = 2,
  parameter int unsigned NumWritePorts = 1,
  parameter int unsigned DataWidth     = 32
);
  logic [5*NumReadPorts-1:0]          raddr_i;
  logic [DataWidth*NumReadPorts-1:0]  rdata_o;
  logic [5*NumWritePorts-1:0]         waddr_i;
  logic [DataWidth*NumWritePorts-1:0] wdata_i;
  logic [NumWritePorts-1:0]           we_i;
  logic                               wipe_req_i;
  logic                               wipe_busy_o;
  logic                               wipe_done_o;
  logic                               err_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, wipe_req_i,
    input  rdata_o, wipe_busy_o, wipe_done_o, err_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, wipe_req_i,
    output rdata_o, wipe_busy_o, wipe_done_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/ibex_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : ibex_register_file_mp
// Description : Parametrised multi-port flop register file. Register 0 is
//               hardwired to WordZeroVal. Combinational reads with optional
//               write-through, up to two write ports (higher index wins),
//               a sequential secure-wipe engine and a sticky write-enable
//               glitch alarm.
//   clk    rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    ibex_register_file_mp_if.slave (read/write ports, wipe handshake,
//          error alarm)
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_register_file_mp #(
  parameter int unsigned          NumRegs       = 32,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          NumReadPorts  = 2,
  parameter int unsigned          NumWritePorts = 1,
  parameter bit                   WriteThrough  = 1'b0,
  parameter bit                   WrenCheck     = 1'b1,
  parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
  input  logic                   clk,
  input  logic                   rst_i,
  ibex_register_file_mp_if.slave bus
);

  localparam logic [4:0]         LastReg   = 5'(NumRegs - 1);
  localparam logic [NumRegs-1:0] RegZeroOh = NumRegs'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WIPE = 2'd1,
    DONE = 2'd2
  } wipe_state_e;

  wipe_state_e state_q, state_d;
  logic [4:0]  wipe_cnt_q, wipe_cnt_d;
  logic        wipe_done;
  logic        busy;

  // Decoded per-register enables; bit 0 is never a real target.
  logic [NumRegs-1:0]                     wipe_wen;
  logic [NumWritePorts-1:0][NumRegs-1:0]  port_wen;
  logic [NumRegs-1:0][DataWidth-1:0]      rf_all;

  // --------------------------------------------------------------------------
  // Wipe engine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wipe_cnt_q <= 5'd1;
    end else begin
      state_q    <= state_d;
      wipe_cnt_q <= wipe_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wipe_cnt_d = wipe_cnt_q;
    wipe_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wipe_req_i) state_d = WIPE;
      end
      WIPE: begin
        if (wipe_cnt_q == LastReg) begin
          state_d = DONE;
        end else begin
          wipe_cnt_d = wipe_cnt_q + 5'd1;
        end
      end
      DONE: begin
        wipe_done  = 1'b1;
        wipe_cnt_d = 5'd1;
        state_d    = IDLE;
      end
      default: begin
        state_d    = IDLE;
        wipe_cnt_d = 5'd1;
      end
    endcase
  end

  assign busy            = (state_q != IDLE);
  assign bus.wipe_busy_o = busy;
  assign bus.wipe_done_o = wipe_done;

  always_comb begin
    wipe_wen = '0;
    for (int r = 1; r < int'(NumRegs); r++) begin
      wipe_wen[r] = (state_q == WIPE) && (wipe_cnt_q == 5'(r));
    end
  end

  // --------------------------------------------------------------------------
  // Write-port address decode. Writes are blocked while the wipe engine runs;
  // out-of-range and x0 addresses simply match no register.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < int'(NumWritePorts); k++) begin : g_wdec
    logic [4:0]         waddr;
    logic [NumRegs-1:0] wen;

    assign waddr = bus.waddr_i[5*k +: 5];

    always_comb begin
      wen = '0;
      for (int r = 1; r < int'(NumRegs); r++) begin
        wen[r] = bus.we_i[k] && !busy && (waddr == 5'(r));
      end
    end

    assign port_wen[k] = wen;
  end

  // --------------------------------------------------------------------------
  // Storage. Later ports override earlier ones; wipe overrides everything.
  // --------------------------------------------------------------------------
  assign rf_all[0] = WordZeroVal;

  for (genvar r = 1; r < int'(NumRegs); r++) begin : g_reg
    logic [DataWidth-1:0] reg_q, reg_d;

    always_comb begin
      reg_d = reg_q;
      for (int k = 0; k < int'(NumWritePorts); k++) begin
        if (port_wen[k][r]) reg_d = bus.wdata_i[DataWidth*k +: DataWidth];
      end
      if (wipe_wen[r]) reg_d = WordZeroVal;
    end

    always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
        reg_q <= WordZeroVal;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign rf_all[r] = reg_q;
  end

  // --------------------------------------------------------------------------
  // Read ports. Addresses at or above NumRegs fall through to WordZeroVal.
  // Write-through follows the same decoded enables as storage, so a blocked
  // write (busy, x0, out of range) is never forwarded.
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < int'(NumReadPorts); p++) begin : g_rd
    logic [4:0]           raddr;
    logic [DataWidth-1:0] rdata;

    assign raddr = bus.raddr_i[5*p +: 5];

    always_comb begin
      rdata = WordZeroVal;
      for (int r = 0; r < int'(NumRegs); r++) begin
        if (raddr == 5'(r)) rdata = rf_all[r];
      end
      if (WriteThrough) begin
        for (int k = 0; k < int'(NumWritePorts); k++) begin
          for (int r = 1; r < int'(NumRegs); r++) begin
            if ((raddr == 5'(r)) && port_wen[k][r]) begin
              rdata = bus.wdata_i[DataWidth*k +: DataWidth];
            end
          end
        end
      end
    end

    assign bus.rdata_o[DataWidth*p +: DataWidth] = rdata;
  end

  // --------------------------------------------------------------------------
  // Write-enable glitch alarm: each port's decode must be zero/one-hot over
  // x1..xN-1 and must never collide with the wipe engine's enable.
  // --------------------------------------------------------------------------
  if (WrenCheck) begin : g_chk
    logic glitch;
    logic err_q;

    always_comb begin
      glitch = 1'b0;
      for (int k = 0; k < int'(NumWritePorts); k++) begin
        if (((port_wen[k] & ~RegZeroOh) & ((port_wen[k] & ~RegZeroOh) - RegZeroOh)) != '0) begin
          glitch = 1'b1;
        end
        if ((port_wen[k] & wipe_wen) != '0) glitch = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
        err_q <= 1'b0;
      end else if (glitch) begin
        err_q <= 1'b1;
      end
    end

    assign bus.err_o = err_q;
  end else begin : g_nochk
    assign bus.err_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_register_file_mp
// Description : Self-checking bench. Two register files driven in lock-step:
//               A = 32 regs, 2R/2W, write-through, glitch check, zero = 0
//               B = 16 regs, 2R/2W, no write-through, no glitch check,
//                   zero = 0xA5A50000
//               Outputs are compared each cycle with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_register_file_mp;

  localparam logic [31:0] ZV_A = 32'h0000_0000;
  localparam logic [31:0] ZV_B = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]  ra [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [1:0]  we;
  logic        req;

  ibex_register_file_mp_if #(.NumReadPorts(2), .NumWritePorts(2), .DataWidth(32)) bus_a ();
  ibex_register_file_mp_if #(.NumReadPorts(2), .NumWritePorts(2), .DataWidth(32)) bus_b ();

  assign bus_a.raddr_i    = {ra[1], ra[0]};
  assign bus_a.waddr_i    = {wa[1], wa[0]};
  assign bus_a.wdata_i    = {wd[1], wd[0]};
  assign bus_a.we_i       = we;
  assign bus_a.wipe_req_i = req;
  assign bus_b.raddr_i    = {ra[1], ra[0]};
  assign bus_b.waddr_i    = {wa[1], wa[0]};
  assign bus_b.wdata_i    = {wd[1], wd[0]};
  assign bus_b.we_i       = we;
  assign bus_b.wipe_req_i = req;

  ibex_register_file_mp #(
    .NumRegs(32), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
    .WriteThrough(1'b1), .WrenCheck(1'b1), .WordZeroVal(ZV_A)
  ) dut_a (.clk(clk), .rst_i(rst), .bus(bus_a));

  ibex_register_file_mp #(
    .NumRegs(16), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
    .WriteThrough(1'b0), .WrenCheck(1'b0), .WordZeroVal(ZV_B)
  ) dut_b (.clk(clk), .rst_i(rst), .bus(bus_b));

  logic [63:0] rdo  [2];
  logic        busyo[2];
  logic        doneo[2];
  logic        erro [2];
  assign rdo[0] = bus_a.rdata_o;     assign rdo[1] = bus_b.rdata_o;
  assign busyo[0] = bus_a.wipe_busy_o; assign busyo[1] = bus_b.wipe_busy_o;
  assign doneo[0] = bus_a.wipe_done_o; assign doneo[1] = bus_b.wipe_done_o;
  assign erro[0] = bus_a.err_o;      assign erro[1] = bus_b.err_o;

  // ---------------- behavioural model ----------------
  // wc[i] = 0 idle, otherwise number of cycles since the wipe was accepted:
  // 1..N-1 clears register wc, N is the completion cycle.
  logic [31:0] mem [2][32];
  int          wc  [2];
  bit          errx[2];
  int          nr  [2];
  bit          wt  [2];
  logic [31:0] zv  [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0 || int'(a) >= nr[i]) return zv[i];
    v = mem[i][a];
    if (wt[i] && wc[i] == 0) begin
      for (int k = 0; k < 2; k++)
        if (we[k] && wa[k] == a) v = wd[k];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) mem[i][r] = zv[i];
      wc[i]   = 0;
      errx[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (wc[i] == 0) begin
        for (int k = 0; k < 2; k++)
          if (we[k] && wa[k] != 5'd0 && int'(wa[k]) < nr[i]) mem[i][wa[k]] = wd[k];
        if (req) wc[i] = 1;
      end else if (wc[i] < nr[i]) begin
        mem[i][wc[i]] = zv[i];
        wc[i]++;
      end else begin
        wc[i] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    string nm;
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "A" : "B";
      for (int p = 0; p < 2; p++)
        check_val($sformatf("%s rd%0d x%0d", nm, p, ra[p]), rdo[i][32*p +: 32], exp_rd(i, ra[p]));
      check_val({nm, " busy"}, 32'(busyo[i]), 32'(wc[i] != 0));
      check_val({nm, " done"}, 32'(doneo[i]), 32'(wc[i] == nr[i]));
      check_val({nm, " err"},  32'(erro[i]),  32'(errx[i]));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drv(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] e,
                     input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1, input logic q);
    ra[0] = r0; ra[1] = r1; we = e;
    wa[0] = a0; wd[0] = d0; wa[1] = a1; wd[1] = d1; req = q;
  endtask

  task automatic idle(input int n);
    drv(5'd1, 5'd2, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    repeat (n) cycle();
  endtask

  initial begin
    nr[0] = 32; wt[0] = 1'b1; zv[0] = ZV_A;
    nr[1] = 16; wt[1] = 1'b0; zv[1] = ZV_B;
    rst = 1'b1;
    drv(5'd0, 5'd5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    model_reset();
    #8;
    check_outputs();                  // reset state
    rst = 1'b0;

    // x5 = DEADBEEF, read on both ports
    drv(5'd5, 5'd5, 2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0);
    cycle();
    drv(5'd5, 5'd5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    cycle();
    // x0 write is dropped
    drv(5'd0, 5'd0, 2'b01, 5'd0, 32'h0000_1234, 5'd0, 32'h0, 1'b0);
    cycle();
    drv(5'd0, 5'd5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    cycle();
    // x4 then x20 (out of range for B)
    drv(5'd4, 5'd20, 2'b11, 5'd4, 32'h4444_4444, 5'd20, 32'h0000_00AA, 1'b0);
    cycle();
    drv(5'd20, 5'd4, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    cycle();
    // both ports write x7, same-cycle read
    drv(5'd7, 5'd4, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0);
    cycle();
    drv(5'd7, 5'd7, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    cycle();

    // randomized traffic including occasional wipe requests
    for (int n = 0; n < 400; n++) begin
      drv(5'($urandom), 5'($urandom), 2'($urandom), 5'($urandom), $urandom,
          5'($urandom), $urandom, ($urandom_range(0, 39) == 0));
      cycle();
    end
    idle(36);

    // fill x1..x31, wipe, attempt a write to x3 while busy
    for (int r = 1; r < 32; r++) begin
      drv(5'(r), 5'(r - 1), 2'b01, 5'(r), 32'h0101_0101 * r + 32'h5A00_0000, 5'd0, 32'h0, 1'b0);
      cycle();
    end
    drv(5'd3, 5'd31, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    cycle();
    drv(5'd3, 5'd31, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    repeat (4) cycle();
    drv(5'd3, 5'd2, 2'b01, 5'd3, 32'hBAD0_0003, 5'd0, 32'h0, 1'b0);
    cycle();
    drv(5'd3, 5'd31, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    repeat (30) cycle();
    for (int r = 0; r < 16; r++) begin
      drv(5'(2 * r), 5'(2 * r + 1), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
      cycle();
    end

    // back-to-back wipe with request held high
    drv(5'd1, 5'd2, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    repeat (40) cycle();
    idle(36);

    // refill a few registers, then reset during the 10th wipe cycle
    for (int r = 1; r < 16; r++) begin
      drv(5'(r), 5'd0, 2'b11, 5'(r), $urandom, 5'(r + 16), $urandom, 1'b0);
      cycle();
    end
    drv(5'd12, 5'd20, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    cycle();
    drv(5'd12, 5'd20, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    repeat (9) cycle();
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();                  // busy/done drop immediately
    #1;
    rst = 1'b0;
    for (int r = 0; r < 16; r++) begin
      drv(5'(2 * r), 5'(2 * r + 1), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
      cycle();
    end
    drv(5'd1, 5'd2, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    cycle();
    idle(36);

    // two-hot decoded enable on port 0 for one cycle
    drv(5'd1, 5'd2, 2'b00, 5'd0, 32'hC0FF_EE00, 5'd0, 32'h0, 1'b0);
    force dut_a.g_wdec[0].wen = 32'h0000_0018;
    force dut_b.g_wdec[0].wen = 16'h0018;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    for (int i = 0; i < 2; i++) begin
      mem[i][3] = wd[0];
      mem[i][4] = wd[0];
    end
    errx[0] = 1'b1;
    #1;
    release dut_a.g_wdec[0].wen;
    release dut_b.g_wdec[0].wen;
    drv(5'd3, 5'd4, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    repeat (6) cycle();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1;
    rst = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
